// File: rtl/spi_pkg.sv
// Shared definitions for the multi-device SPI master: state encoding and default sizing.
package spi_pkg;

    localparam int DEF_N_CS     = 2;
    localparam int DEF_MAX_BITS = 24;
    localparam int DEF_DIV_W    = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_SETUP    = 3'd1;
    localparam state_t ST_SHIFT    = 3'd2;
    localparam state_t ST_HOLD     = 3'd3;
    localparam state_t ST_DONE     = 3'd4;
    localparam state_t ST_WAIT_REL = 3'd5;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: emits a one-cycle tick every div+1 enabled cycles, restartable via load.
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load || tick) begin
            cnt_reg <= div;
        end else if (en) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

endmodule

// File: rtl/multi_spi_ctrl.sv
// SPI master with N_CS chip selects, per-request length/polarity/divider, and a
// level req / pulse ack handshake that needs req to drop before the next transfer.
module multi_spi_ctrl
    import spi_pkg::*;
#(
    parameter int N_CS     = DEF_N_CS,
    parameter int MAX_BITS = DEF_MAX_BITS,
    parameter int DIV_W    = DEF_DIV_W,
    localparam int CS_W    = (N_CS > 1) ? $clog2(N_CS) : 1,
    localparam int NB_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    output logic                ack,
    output logic                err,
    output logic                busy,
    input  logic [CS_W-1:0]     cs_sel,
    input  logic [NB_W-1:0]     nbits,
    input  logic                rd_en,
    input  logic                cpol,
    input  logic [DIV_W-1:0]    div,
    input  logic [MAX_BITS-1:0] wr_data,
    output logic [MAX_BITS-1:0] rd_data,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [N_CS-1:0]     cs_n
);

    localparam int HC_W = $clog2(2 * MAX_BITS + 1);

    state_t state_reg, state_next;

    logic [NB_W-1:0]     nbits_lat;
    logic                rd_en_lat;
    logic                cpol_lat;
    logic [DIV_W-1:0]    div_lat;
    logic                valid_reg;
    logic [MAX_BITS-1:0] tx_reg;
    logic [MAX_BITS-1:0] rx_reg;
    logic [MAX_BITS-1:0] rd_data_reg;
    logic [HC_W-1:0]     half_cnt;
    logic [HC_W-1:0]     last_idx;
    logic                sclk_reg;
    logic                mosi_reg;
    logic [N_CS-1:0]     cs_n_reg;
    logic [N_CS-1:0]     cs_dec;
    logic [NB_W-1:0]     pad;
    logic [MAX_BITS-1:0] tx_aligned;
    logic                req_valid;
    logic                tick;
    logic                tick_en;
    logic                tick_load;

    genvar gi;
    generate
        for (gi = 0; gi < N_CS; gi++) begin : g_cs_dec
            assign cs_dec[gi] = (32'(cs_sel) == gi);
        end
    endgenerate

    assign req_valid  = (nbits != '0) && (32'(nbits) <= MAX_BITS) && (32'(cs_sel) < N_CS);
    // Left-align the word so the MSB of the transfer always sits at the top of tx_reg.
    assign pad        = NB_W'(MAX_BITS) - nbits;
    assign tx_aligned = wr_data << pad;
    assign last_idx   = HC_W'({nbits_lat, 1'b0}) - HC_W'(1);
    assign tick_load  = (state_reg == ST_IDLE);

    spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (tick_load),
        .en   (tick_en),
        .div  (tick_load ? div : div_lat),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A rejected request still spends one cycle in SETUP (with cs_n idle) so ack lands one cycle after accept.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (req) state_next = ST_SETUP;
            ST_SETUP:    if (!valid_reg) state_next = ST_DONE;
                         else if (tick) state_next = ST_SHIFT;
            ST_SHIFT:    if (tick && (half_cnt == last_idx)) state_next = ST_HOLD;
            ST_HOLD:     if (tick) state_next = ST_DONE;
            ST_DONE:     state_next = ST_WAIT_REL;
            ST_WAIT_REL: if (!req) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ack     = 1'b0;
        err     = 1'b0;
        busy    = (state_reg != ST_IDLE);
        tick_en = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT) || (state_reg == ST_HOLD);
        if (state_reg == ST_DONE) begin
            ack = 1'b1;
            err = ~valid_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nbits_lat   <= '0;
            rd_en_lat   <= 1'b0;
            cpol_lat    <= 1'b0;
            div_lat     <= '0;
            valid_reg   <= 1'b0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            rd_data_reg <= '0;
            half_cnt    <= '0;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            cs_n_reg    <= '1;
        end else begin
            case (state_reg)
                ST_IDLE: if (req) begin
                    nbits_lat <= nbits;
                    rd_en_lat <= rd_en;
                    cpol_lat  <= cpol;
                    div_lat   <= div;
                    valid_reg <= req_valid;
                    half_cnt  <= '0;
                    rx_reg    <= '0;
                    if (req_valid) begin
                        cs_n_reg <= ~cs_dec;
                        sclk_reg <= cpol;
                        tx_reg   <= tx_aligned;
                        mosi_reg <= tx_aligned[MAX_BITS-1];
                    end
                end
                ST_SHIFT: if (tick) begin
                    sclk_reg <= ~sclk_reg;
                    half_cnt <= half_cnt + 1'b1;
                    if (sclk_reg == cpol_lat) begin
                        rx_reg <= {rx_reg[MAX_BITS-2:0], miso};
                    end else if (half_cnt != last_idx) begin
                        tx_reg   <= tx_reg << 1;
                        mosi_reg <= tx_reg[MAX_BITS-2];
                    end
                end
                ST_HOLD: if (tick) begin
                    cs_n_reg <= '1;
                    if (rd_en_lat) rd_data_reg <= rx_reg;
                end
                default: ;
            endcase
        end
    end

    assign sclk    = sclk_reg;
    assign mosi    = mosi_reg;
    assign cs_n    = cs_n_reg;
    assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_multi_spi_ctrl.sv
// Scoreboard bench for multi_spi_ctrl: a slave model feeds MISO and captures MOSI; expectations are queued per request.
module tb_multi_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        ack, err, busy;
    logic [0:0]  cs_sel = '0;
    logic [4:0]  nbits = '0;
    logic        rd_en = 1'b0;
    logic        cpol = 1'b0;
    logic [7:0]  div = '0;
    logic [23:0] wr_data = '0;
    logic [23:0] rd_data;
    logic        sclk, mosi;
    logic        miso = 1'b0;
    logic [1:0]  cs_n;

    logic        req3 = 1'b0;
    logic [1:0]  cs_sel3 = '0;
    logic        ack3, err3, busy3, sclk3, mosi3;
    logic [23:0] rd_data3;
    logic [2:0]  cs_n3;

    multi_spi_ctrl #(.N_CS(2), .MAX_BITS(24), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .err(err), .busy(busy),
        .cs_sel(cs_sel), .nbits(nbits), .rd_en(rd_en), .cpol(cpol), .div(div),
        .wr_data(wr_data), .rd_data(rd_data), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    // Three-device instance so an out-of-range index is representable on cs_sel.
    multi_spi_ctrl #(.N_CS(3), .MAX_BITS(24), .DIV_W(8)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .ack(ack3), .err(err3), .busy(busy3),
        .cs_sel(cs_sel3), .nbits(nbits), .rd_en(rd_en), .cpol(cpol), .div(div),
        .wr_data(wr_data), .rd_data(rd_data3), .sclk(sclk3), .mosi(mosi3),
        .miso(miso), .cs_n(cs_n3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          latency;
        logic        err;
        logic [23:0] rd;
        logic [23:0] mosi_word;
        int          mosi_bits;
        logic [1:0]  cs;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          multi_low = 0;
    logic        tb_cpol = 1'b0;
    logic [23:0] miso_word = '0;
    int          miso_idx = -1;
    logic [23:0] mosi_cap = '0;
    int          mosi_cnt = 0;
    logic [1:0]  cs_seen = 2'b11;
    logic        sclk_prev = 1'b0;
    logic        cs_act_prev = 1'b0;
    logic [23:0] exp_rd = '0;

    always @(posedge clk) cyc++;

    // Slave model: shifts MISO on trailing edges, records MOSI on leading edges.
    always @(negedge clk) begin
        if (ack) ack_cnt++;
        if ($countones(~cs_n) > 1) multi_low++;
        cs_seen = cs_seen & cs_n;
        if (!(&cs_n) && cs_act_prev) begin
            if (sclk_prev != tb_cpol && sclk == tb_cpol) begin
                miso_idx--;
                if (miso_idx >= 0) miso = miso_word[miso_idx];
            end
            if (sclk_prev == tb_cpol && sclk != tb_cpol) begin
                mosi_cap = {mosi_cap[22:0], mosi};
                mosi_cnt++;
            end
        end
        cs_act_prev = !(&cs_n);
        sclk_prev   = sclk;
    end

    task automatic run_xfer(input string name, input int sel, input int nb, input logic rde,
                            input logic cp, input int dv, input logic [23:0] wr,
                            input logic [23:0] mw, input int hold_cycles, input bit change_mid);
        exp_t        e;
        bit          valid;
        bit          got;
        int          accept_cyc;
        int          lat;
        int          busy_low;
        int          ack_base;
        logic [31:0] mask;
        logic [1:0]  one;
        valid = (nb != 0) && (nb <= 24) && (sel < 2);
        mask  = (32'h1 << nb) - 32'h1;
        one   = 2'b01 << sel;
        if (valid && rde) exp_rd = 24'(32'(mw) & mask);
        e.latency   = valid ? (2 * nb + 2) * (dv + 1) : 1;
        e.err       = !valid;
        e.rd        = exp_rd;
        e.mosi_word = valid ? 24'(32'(wr) & mask) : 24'h0;
        e.mosi_bits = valid ? nb : 0;
        e.cs        = valid ? ~one : 2'b11;
        sb.push_back(e);

        @(negedge clk);
        cs_sel = 1'(sel); nbits = 5'(nb); rd_en = rde; cpol = cp; div = 8'(dv); wr_data = wr;
        tb_cpol = cp; miso_word = mw; mosi_cap = '0; mosi_cnt = 0; cs_seen = 2'b11;
        miso_idx = nb - 1;
        if (nb >= 1 && nb <= 24) miso = mw[nb-1];
        req = 1'b1;
        @(posedge clk);
        #1 accept_cyc = cyc;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (change_mid && mosi_cnt == 3) begin
                wr_data = ~wr;
                cs_sel  = ~cs_sel;
            end
            if (ack) got = 1;
        end
        lat = cyc - accept_cyc;
        e = sb.pop_front();

        checks++;
        if (!got) begin failures++; $display("FAIL %s ack_timeout got=no ack exp=ack", name); end
        checks++;
        if (lat !== e.latency) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, e.latency); end
        checks++;
        if (err !== e.err) begin failures++; $display("FAIL %s err got=%b exp=%b", name, err, e.err); end
        checks++;
        if (rd_data !== e.rd) begin failures++; $display("FAIL %s rd_data got=%h exp=%h", name, rd_data, e.rd); end
        checks++;
        if (mosi_cnt !== e.mosi_bits) begin failures++; $display("FAIL %s mosi_bits got=%0d exp=%0d", name, mosi_cnt, e.mosi_bits); end
        checks++;
        if (mosi_cap !== e.mosi_word) begin failures++; $display("FAIL %s mosi_word got=%h exp=%h", name, mosi_cap, e.mosi_word); end
        checks++;
        if (cs_seen !== e.cs) begin failures++; $display("FAIL %s cs_n_used got=%b exp=%b", name, cs_seen, e.cs); end
        checks++;
        if (cs_n !== 2'b11) begin failures++; $display("FAIL %s cs_n_at_ack got=%b exp=11", name, cs_n); end

        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL %s ack_width got=%b exp=0", name, ack); end

        if (hold_cycles > 0) begin
            busy_low = 0;
            ack_base = ack_cnt;
            repeat (hold_cycles) begin
                @(negedge clk);
                if (busy !== 1'b1) busy_low++;
            end
            checks++;
            if (busy_low !== 0) begin failures++; $display("FAIL %s busy_hold got=%0d low cycles exp=0", name, busy_low); end
            checks++;
            if (ack_cnt !== ack_base) begin failures++; $display("FAIL %s retrigger got=%0d acks exp=0", name, ack_cnt - ack_base); end
        end
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_release got=%b exp=0", name, busy); end
        $display("xfer %s sel=%0d nbits=%0d div=%0d cpol=%b latency=%0d err=%b rd=%h mosi=%h", name, sel, nb, dv, cp, lat, err, rd_data, mosi_cap);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (cs_n !== 2'b11 || sclk !== 1'b0 || mosi !== 1'b0) begin
            failures++; $display("FAIL reset_outputs got=cs_n %b sclk %b mosi %b exp=11 0 0", cs_n, sclk, mosi);
        end
        checks++;
        if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rd_data !== 24'h0) begin
            failures++; $display("FAIL reset_status got=ack %b err %b busy %b rd %h exp=0 0 0 0", ack, err, busy, rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset released cs_n=%b sclk=%b", cs_n, sclk);
    endtask

    task automatic test_write;
        run_xfer("write", 1, 24, 1'b0, 1'b0, 2, 24'hA5C3F0, 24'h0, 0, 0);
    endtask

    task automatic test_read;
        run_xfer("read", 0, 16, 1'b1, 1'b1, 0, 24'h1234, 24'h3C96, 0, 0);
        checks++;
        if (sclk !== 1'b1) begin failures++; $display("FAIL read_sclk_idle got=%b exp=1", sclk); end
    endtask

    task automatic test_reject;
        logic s0, m0;
        s0 = sclk; m0 = mosi;
        run_xfer("reject_nbits", 0, 25, 1'b1, 1'b0, 3, 24'hFFFFFF, 24'hABCDEF, 0, 0);
        checks++;
        if (sclk !== s0 || mosi !== m0) begin
            failures++; $display("FAIL reject_lines got=sclk %b mosi %b exp=%b %b", sclk, mosi, s0, m0);
        end
        run_xfer("reject_zero", 1, 0, 1'b1, 1'b0, 3, 24'h1, 24'h1, 0, 0);
    endtask

    task automatic test_reject_cs;
        bit         got;
        int         acc;
        int         lat;
        logic [2:0] seen;
        @(negedge clk);
        cs_sel3 = 2'd3; nbits = 5'd8; rd_en = 1'b1; div = 8'd1; req3 = 1'b1;
        seen = 3'b111;
        @(posedge clk);
        #1 acc = cyc;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            seen = seen & cs_n3;
            if (ack3) got = 1;
        end
        lat = cyc - acc;
        checks++;
        if (!got || lat !== 1) begin failures++; $display("FAIL reject_cs latency got=%0d (ack %b) exp=1", lat, got); end
        checks++;
        if (err3 !== 1'b1) begin failures++; $display("FAIL reject_cs err got=%b exp=1", err3); end
        checks++;
        if (seen !== 3'b111 || rd_data3 !== 24'h0) begin
            failures++; $display("FAIL reject_cs lines got=cs_n %b rd %h exp=111 000000", seen, rd_data3);
        end
        req3 = 1'b0;
        @(negedge clk);
        $display("xfer reject_cs sel=3 latency=%0d err=%b cs_n=%b", lat, err3, seen);
    endtask

    task automatic test_handshake;
        run_xfer("handshake", 1, 8, 1'b0, 1'b0, 0, 24'h3C, 24'h0, 500, 0);
        run_xfer("after_hs", 0, 12, 1'b1, 1'b0, 1, 24'hABC, 24'h5E1, 0, 0);
    endtask

    task automatic test_reset_mid;
        int base;
        bit reached;
        @(negedge clk);
        cs_sel = 1'b0; nbits = 5'd8; rd_en = 1'b1; cpol = 1'b0; div = 8'd1; wr_data = 24'hFF;
        tb_cpol = 1'b0; miso_word = 24'hFF; miso_idx = 7; miso = 1'b1;
        mosi_cap = '0; mosi_cnt = 0;
        base = ack_cnt;
        req = 1'b1;
        reached = 0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (mosi_cnt == 5) reached = 1;
        end
        checks++;
        if (!reached) begin failures++; $display("FAIL reset_mid reach_bit5 got=%0d bits exp=5", mosi_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cs_n !== 2'b11 || sclk !== 1'b0) begin
            failures++; $display("FAIL reset_mid async got=cs_n %b sclk %b exp=11 0", cs_n, sclk);
        end
        req = 1'b0;
        exp_rd = 24'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ack_cnt !== base || busy !== 1'b0 || rd_data !== 24'h0) begin
            failures++; $display("FAIL reset_mid abort got=acks %0d busy %b rd %h exp=0 0 000000", ack_cnt - base, busy, rd_data);
        end
        $display("reset mid-shift cs_n=%b sclk=%b", cs_n, sclk);
        run_xfer("post_reset", 0, 8, 1'b1, 1'b0, 1, 24'h5A, 24'hC3, 0, 0);
    endtask

    task automatic test_input_change;
        run_xfer("input_change", 0, 20, 1'b1, 1'b0, 1, 24'h9B3D1, 24'h71E2C, 0, 1);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 6; k++) begin
            run_xfer("random", int'($urandom_range(0, 1)), int'($urandom_range(1, 24)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     24'($urandom), 24'($urandom), 0, 0);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_reject;
        test_reject_cs;
        test_handshake;
        test_reset_mid;
        test_input_change;
        test_back_to_back;
        checks++;
        if (multi_low !== 0) begin failures++; $display("FAIL cs_onehot got=%0d cycles exp=0", multi_low); end
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
